// File: rtl/cpu_pkg.sv
// Shared pipeline types: RISC-V load funct3 encodings and the writeback queue entry.
// Entry fields are sized for the widest supported configuration; users truncate to their widths.
package cpu_pkg;

    localparam int XLEN_MAX  = 64;
    localparam int REG_W_MAX = 8;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LD  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;
    localparam logic [2:0] LD_LWU = 3'b110;

    typedef struct packed {
        logic                 wen;
        logic [REG_W_MAX-1:0] rd;
        logic [XLEN_MAX-1:0]  data;
    } wb_entry_t;

endpackage

// File: rtl/load_align.sv
// Load data formatter: picks the byte/half/word lane from addr_lo and sign/zero-extends.
// Purely combinational, no handshake; non-loads and LD/unknown encodings pass through.
module load_align
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]             data,
    input  logic [2:0]                  fmt,
    input  logic [$clog2(XLEN/8)-1:0]   addr_lo,
    input  logic                        is_load,
    output logic [XLEN-1:0]             formatted
);

    localparam int AW = $clog2(XLEN/8);

    logic [AW-1:0]   half_lane;
    logic            word_lane;
    logic [XLEN-1:0] byte_sh;
    logic [XLEN-1:0] half_sh;
    logic [XLEN-1:0] word_sh;

    always_comb begin
        half_lane    = addr_lo;
        half_lane[0] = 1'b0;
        // Only a 64-bit datapath has two word lanes.
        word_lane    = (XLEN == 64) ? addr_lo[AW-1] : 1'b0;
        byte_sh      = data >> {addr_lo, 3'b000};
        half_sh      = data >> {half_lane, 3'b000};
        word_sh      = data >> {word_lane, 5'b00000};
    end

    always_comb begin
        formatted = data;
        if (is_load) begin
            case (fmt)
                LD_LB:   formatted = XLEN'($signed(byte_sh[7:0]));
                LD_LBU:  formatted = XLEN'(byte_sh[7:0]);
                LD_LH:   formatted = XLEN'($signed(half_sh[15:0]));
                LD_LHU:  formatted = XLEN'(half_sh[15:0]);
                LD_LW:   formatted = XLEN'($signed(word_sh[31:0]));
                LD_LWU:  formatted = XLEN'(word_sh[31:0]);
                default: formatted = data;
            endcase
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: formats loads, queues results in a 2-entry FIFO, drives the shared regfile port.
// Latency 1 cycle accept-to-write; in_ready drops when the queue is full (registered, no grant path).
module writeback_unit
    import cpu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int REG_W = 6,
    parameter int CNT_W = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_writeback,
    input  logic [XLEN-1:0]             in_data,
    input  logic [REG_W-1:0]            in_rd,
    input  logic                        in_is_load,
    input  logic [2:0]                  in_ld_fmt,
    input  logic [$clog2(XLEN/8)-1:0]   in_addr_lo,
    output logic [XLEN-1:0]             regdata,
    output logic [REG_W-1:0]            regno,
    output logic                        write,
    input  logic                        rf_grant,
    output logic                        byp0_valid,
    output logic [REG_W-1:0]            byp0_rd,
    output logic [XLEN-1:0]             byp0_data,
    output logic                        byp1_valid,
    output logic [REG_W-1:0]            byp1_rd,
    output logic [XLEN-1:0]             byp1_data,
    output logic [CNT_W-1:0]            instret
);

    wb_entry_t       mem [2];
    logic            wp;
    logic            rp;
    logic [1:0]      count;
    logic [1:0]      count_nxt;
    logic            rdy;
    logic            push;
    logic            pop;
    logic            head_vld;
    logic            tail_vld;
    wb_entry_t       head;
    wb_entry_t       tail;
    logic [XLEN-1:0] fmt_data;
    logic            wb_unused;

    load_align #(.XLEN(XLEN)) u_load_align (
        .data      (in_data),
        .fmt       (in_ld_fmt),
        .addr_lo   (in_addr_lo),
        .is_load   (in_is_load),
        .formatted (fmt_data)
    );

    assign head     = mem[rp];
    assign tail     = mem[~rp];
    assign head_vld = (count != 2'd0);
    assign tail_vld = (count == 2'd2);

    assign in_ready = rdy;
    assign push     = in_valid & rdy;
    assign write    = head_vld & head.wen;
    // Non-writing entries drain without waiting for the shared port.
    assign pop      = head_vld & (~head.wen | rf_grant);

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            wp      <= 1'b0;
            rp      <= 1'b0;
            count   <= 2'd0;
            rdy     <= 1'b0;
            instret <= '0;
        end else begin
            if (push) begin
                mem[wp] <= '{wen:  in_writeback & (in_rd != '0),
                             rd:   REG_W_MAX'(in_rd),
                             data: XLEN_MAX'(fmt_data)};
                wp      <= ~wp;
            end
            if (pop) begin
                rp      <= ~rp;
                instret <= instret + CNT_W'(1);
            end
            count <= count_nxt;
            // Ready is precomputed from next occupancy so it never sees rf_grant combinationally.
            rdy   <= (count_nxt != 2'd2);
        end
    end

    assign regdata    = head_vld ? head.data[XLEN-1:0] : '0;
    assign regno      = head_vld ? head.rd[REG_W-1:0]  : '0;

    assign byp0_valid = write;
    assign byp0_rd    = head_vld ? head.rd[REG_W-1:0]  : '0;
    assign byp0_data  = head_vld ? head.data[XLEN-1:0] : '0;
    assign byp1_valid = tail_vld & tail.wen;
    assign byp1_rd    = tail_vld ? tail.rd[REG_W-1:0]  : '0;
    assign byp1_data  = tail_vld ? tail.data[XLEN-1:0] : '0;

    // Entry bits above the configured widths are always zero.
    assign wb_unused = |(mem[0].data >> XLEN) | |(mem[1].data >> XLEN)
                     | |(mem[0].rd >> REG_W)  | |(mem[1].rd >> REG_W);

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: load formatting, rd=0 suppression, stall/drain, push+pop, reset.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_writeback;
    logic [31:0] in_data;
    logic [5:0]  in_rd;
    logic        in_is_load;
    logic [2:0]  in_ld_fmt;
    logic [1:0]  in_addr_lo;
    logic [31:0] regdata;
    logic [5:0]  regno;
    logic        write;
    logic        rf_grant;
    logic        byp0_valid;
    logic [5:0]  byp0_rd;
    logic [31:0] byp0_data;
    logic        byp1_valid;
    logic [5:0]  byp1_rd;
    logic [31:0] byp1_data;
    logic [63:0] instret;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    writeback_unit #(.XLEN(32), .REG_W(6), .CNT_W(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_writeback (in_writeback),
        .in_data      (in_data),
        .in_rd        (in_rd),
        .in_is_load   (in_is_load),
        .in_ld_fmt    (in_ld_fmt),
        .in_addr_lo   (in_addr_lo),
        .regdata      (regdata),
        .regno        (regno),
        .write        (write),
        .rf_grant     (rf_grant),
        .byp0_valid   (byp0_valid),
        .byp0_rd      (byp0_rd),
        .byp0_data    (byp0_data),
        .byp1_valid   (byp1_valid),
        .byp1_rd      (byp1_rd),
        .byp1_data    (byp1_data),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_alu(input logic [5:0] rd, input logic [31:0] d);
        in_valid     = 1'b1;
        in_writeback = 1'b1;
        in_rd        = rd;
        in_data      = d;
        in_is_load   = 1'b0;
        in_ld_fmt    = 3'b000;
        in_addr_lo   = 2'd0;
    endtask

    // Load vectors on 0x8081_8283: {funct3, addr_lo, expected}
    logic [2:0]  v_fmt  [9] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011, 3'b111, 3'b001, 3'b101};
    logic [1:0]  v_addr [9] = '{2'd1,   2'd3,   2'd0,   2'd2,   2'd0,   2'd1,   2'd2,   2'd3,   2'd1};
    logic [31:0] v_exp  [9] = '{32'hFFFF_FF82, 32'h0000_0080, 32'hFFFF_8283, 32'h0000_8081,
                                32'h8081_8283, 32'h8081_8283, 32'h8081_8283, 32'hFFFF_8081,
                                32'h0000_8283};

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_writeback = 1'b0; in_data = '0; in_rd = '0;
        in_is_load = 1'b0; in_ld_fmt = '0; in_addr_lo = '0; rf_grant = 1'b0;
        cyc(); cyc();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_write", 64'(write), 64'd0);
        chk("rst_regno", 64'(regno), 64'd0);
        chk("rst_regdata", 64'(regdata), 64'd0);
        chk("rst_instret", instret, 64'd0);
        chk("rst_byp", 64'({byp0_valid, byp0_rd, byp0_data, byp1_valid, byp1_rd, byp1_data}), 64'd0);
        rst = 1'b0;
        cyc();
        chk("ready_after_rst", 64'(in_ready), 64'd1);

        // LB with one-cycle latency
        push_alu(6'd5, 32'h8081_8283);
        in_is_load = 1'b1; in_ld_fmt = 3'b000; in_addr_lo = 2'd1; rf_grant = 1'b1;
        #1;
        chk("lb_not_early", 64'(write), 64'd0);
        cyc();
        in_valid = 1'b0;
        chk("lb_write", 64'(write), 64'd1);
        chk("lb_regno", 64'(regno), 64'd5);
        chk("lb_regdata", 64'(regdata), 64'hFFFF_FF82);
        chk("lb_byp0", 64'({byp0_valid, byp0_rd, byp0_data}), {25'd0, 1'b1, 6'd5, 32'hFFFF_FF82});
        chk("lb_instret_pre", instret, 64'd0);
        cyc();
        chk("lb_instret", instret, 64'd1);
        chk("lb_drained", 64'(write), 64'd0);

        // Back-to-back loads with grant=1: push+pop each cycle at count=1
        for (int i = 0; i < 9; i++) begin
            push_alu(6'(i + 10), 32'h8081_8283);
            in_is_load = 1'b1; in_ld_fmt = v_fmt[i]; in_addr_lo = v_addr[i];
            cyc();
            chk($sformatf("fmt%0d_regdata", i), 64'(regdata), 64'(v_exp[i]));
            chk($sformatf("fmt%0d_regno", i), 64'(regno), 64'(i + 10));
        end
        in_valid = 1'b0;
        chk("chain_no_byp1", 64'(byp1_valid), 64'd0);
        cyc();
        chk("chain_instret", instret, 64'd10);

        // rd=0 never writes but still retires
        rf_grant = 1'b0;
        push_alu(6'd0, 32'h0000_1234);
        cyc();
        in_valid = 1'b0;
        chk("rd0_write", 64'(write), 64'd0);
        chk("rd0_byp0", 64'(byp0_valid), 64'd0);
        chk("rd0_regdata", 64'(regdata), 64'h1234);
        cyc();
        chk("rd0_instret", instret, 64'd11);
        chk("rd0_empty", 64'(regdata), 64'd0);

        // Stall with grant low, then drain in order
        push_alu(6'd1, 32'h11);
        cyc();
        chk("stall_ready1", 64'(in_ready), 64'd1);
        push_alu(6'd2, 32'h22);
        cyc();
        push_alu(6'd3, 32'h33);
        chk("stall_full", 64'(in_ready), 64'd0);
        chk("stall_byp1", 64'({byp1_valid, byp1_rd, byp1_data}), {25'd0, 1'b1, 6'd2, 32'h22});
        for (int k = 0; k < 2; k++) begin
            cyc();
            chk("stall_hold", 64'({in_ready, write, regno, regdata}), {24'd0, 1'b0, 1'b1, 6'd1, 32'h11});
            chk("stall_instret", instret, 64'd11);
        end
        rf_grant = 1'b1;
        cyc();
        chk("drain1", 64'({in_ready, regno, regdata}), {25'd0, 1'b1, 6'd2, 32'h22});
        chk("drain1_instret", instret, 64'd12);
        cyc();
        in_valid = 1'b0;
        chk("drain2", 64'({write, regno, regdata}), {25'd0, 1'b1, 6'd3, 32'h33});
        chk("drain2_instret", instret, 64'd13);
        cyc();
        chk("drain3", 64'({write, instret[31:0]}), {31'd0, 1'b0, 32'd14});

        // Push and pop in the same cycle at count=1
        rf_grant = 1'b0;
        push_alu(6'd4, 32'h44);
        cyc();
        push_alu(6'd6, 32'h66);
        rf_grant = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("pp_head", 64'({write, regno, regdata}), {25'd0, 1'b1, 6'd6, 32'h66});
        chk("pp_count1", 64'({in_ready, byp1_valid}), 64'b10);
        chk("pp_instret", instret, 64'd15);
        cyc();
        chk("pp_instret2", instret, 64'd16);

        // Reset with two entries queued
        rf_grant = 1'b0;
        push_alu(6'd7, 32'h77);
        cyc();
        push_alu(6'd8, 32'h88);
        cyc();
        in_valid = 1'b0;
        chk("mid_full", 64'({in_ready, byp1_valid}), 64'b01);
        rst = 1'b1;
        rf_grant = 1'b1;
        cyc();
        chk("mid_rst_write", 64'(write), 64'd0);
        chk("mid_rst_instret", instret, 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        cyc();
        chk("mid_rst_ready_after", 64'(in_ready), 64'd1);
        chk("mid_rst_empty", 64'({write, byp0_valid, byp1_valid, regno}), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
